quad_step_gen: RTL and testbench



---
 rtl/quad_step_gen.sv | 118 +++++++++++
 tb/tb_quad_step_gen.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/quad_step_gen.sv
// Quadrature step generator.
// Accepts a move command (direction, step count, step period) and emits a two-phase
// Gray-coded A/B pulse train with one phase transition per step. A shadow position
// register tracks the count an x4 quadrature decoder must show.
//
// Ports:
//   clk        - sole clock, rising edge
//   rst        - synchronous active-high reset
//   cmd_valid  - command present
//   cmd_ready  - block can accept a command (state is IDLE)
//   cmd_dir    - 1 = up, 0 = down
//   cmd_steps  - number of phase transitions to emit
//   cmd_period - clock cycles per step (0 treated as 1)
//   quad_a     - phase A (registered)
//   quad_b     - phase B (registered)
//   busy       - high while running a command
//   done       - one-cycle pulse at command completion
//   position   - running step total, mod 2^CNT_W
module quad_step_gen #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned PER_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [PER_W-1:0] cmd_period,
  output logic             quad_a,
  output logic             quad_b,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] position
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q;
  logic             dir_q;
  logic [PER_W-1:0] period_q;
  logic [PER_W-1:0] timer_q;
  logic [CNT_W-1:0] remaining_q;
  logic [1:0]       ab_q;
  logic [CNT_W-1:0] position_q;
  logic             done_q;

  logic [1:0]       ab_next;
  logic [PER_W-1:0] eff_period;

  assign eff_period = (cmd_period == '0) ? PER_W'(1) : cmd_period;

  // Gray sequence {A,B}: up 00->10->11->01->00, down is the reverse.
  always_comb begin
    ab_next = ab_q;
    unique case (ab_q)
      2'b00: ab_next = dir_q ? 2'b10 : 2'b01;
      2'b10: ab_next = dir_q ? 2'b11 : 2'b00;
      2'b11: ab_next = dir_q ? 2'b01 : 2'b10;
      2'b01: ab_next = dir_q ? 2'b00 : 2'b11;
      default: ab_next = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      dir_q       <= 1'b0;
      period_q    <= '0;
      timer_q     <= '0;
      remaining_q <= '0;
      ab_q        <= 2'b00;
      position_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            dir_q    <= cmd_dir;
            period_q <= eff_period;
            if (cmd_steps == '0) begin
              // Empty move completes immediately without touching phase or position.
              done_q <= 1'b1;
            end else begin
              state_q     <= StRun;
              timer_q     <= eff_period;
              remaining_q <= cmd_steps;
            end
          end
        end
        StRun: begin
          if (timer_q == PER_W'(1)) begin
            ab_q        <= ab_next;
            position_q  <= dir_q ? position_q + CNT_W'(1) : position_q - CNT_W'(1);
            remaining_q <= remaining_q - CNT_W'(1);
            timer_q     <= period_q;
            if (remaining_q == CNT_W'(1)) begin
              done_q  <= 1'b1;
              state_q <= StIdle;
            end
          end else begin
            timer_q <= timer_q - PER_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q == StRun);
  assign done      = done_q;
  assign quad_a    = ab_q[1];
  assign quad_b    = ab_q[0];
  assign position  = position_q;

endmodule

// File: tb/tb_quad_step_gen.sv
// Self-checking bench for quad_step_gen: a reference model predicts the per-cycle
// output snapshot for each command into a queue, and every cycle one entry is popped
// and compared against the DUT.
module tb_quad_step_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_dir;
  logic [7:0] cmd_steps;
  logic [7:0] cmd_period;
  logic       quad_a;
  logic       quad_b;
  logic       busy;
  logic       done;
  logic [7:0] position;

  always #5 clk = ~clk;

  quad_step_gen #(
    .CNT_W(8),
    .PER_W(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_steps (cmd_steps),
    .cmd_period(cmd_period),
    .quad_a    (quad_a),
    .quad_b    (quad_b),
    .busy      (busy),
    .done      (done),
    .position  (position)
  );

  // Snapshot layout: {A,B}, busy, done, ready, position.
  typedef logic [12:0] snap_t;

  snap_t      exp_q[$];
  int         n_assert = 0;
  int         n_fail   = 0;
  int         m_idx    = 0;
  logic [7:0] m_pos    = 8'd0;

  function automatic snap_t mk(input int idx, input logic [7:0] pos, input logic b,
                               input logic d);
    logic [1:0] ab;
    case (idx)
      0: ab = 2'b00;
      1: ab = 2'b10;
      2: ab = 2'b11;
      default: ab = 2'b01;
    endcase
    return {ab, b, d, ~b, pos};
  endfunction

  // Push expected snapshots for edges k..k+min(N*P, max_t) after accept edge k.
  task automatic predict(input logic dir, input int steps, input int period, input int max_t);
    int p;
    p = (period == 0) ? 1 : period;
    if (steps == 0) begin
      exp_q.push_back(mk(m_idx, m_pos, 1'b0, 1'b1));
    end else begin
      for (int t = 0; t <= steps * p && t <= max_t; t++) begin
        int         i;
        int         idx;
        logic [7:0] pv;
        i   = t / p;
        idx = dir ? (m_idx + i) % 4 : (m_idx - (i % 4) + 4) % 4;
        pv  = dir ? m_pos + 8'(i) : m_pos - 8'(i);
        exp_q.push_back(mk(idx, pv, t < steps * p, t == steps * p));
      end
      m_idx = dir ? (m_idx + steps) % 4 : (m_idx - (steps % 4) + 4) % 4;
      m_pos = dir ? m_pos + 8'(steps) : m_pos - 8'(steps);
    end
  endtask

  task automatic tick_check(input string tag);
    snap_t obs;
    snap_t e;
    @(posedge clk);
    #1;
    obs = {quad_a, quad_b, busy, done, cmd_ready, position};
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: observed %h with no expected entry", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) tick_check(tag);
  endtask

  task automatic issue(input logic dir, input int steps, input int period, input string tag);
    cmd_valid  = 1'b1;
    cmd_dir    = dir;
    cmd_steps  = 8'(steps);
    cmd_period = 8'(period);
    predict(dir, steps, period, 1 << 20);
    tick_check(tag);
    cmd_valid = 1'b0;
    drain(tag);
  endtask

  task automatic do_reset(input int n, input string tag);
    rst   = 1'b1;
    m_idx = 0;
    m_pos = 8'd0;
    repeat (n) begin
      exp_q.push_back(mk(0, 8'd0, 1'b0, 1'b0));
      tick_check(tag);
    end
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_dir    = 1'b0;
    cmd_steps  = 8'd0;
    cmd_period = 8'd0;

    do_reset(2, "reset");
    exp_q.push_back(mk(0, 8'd0, 1'b0, 1'b0));
    tick_check("idle_after_reset");

    issue(1'b1, 4, 3, "up4_p3");

    do_reset(1, "reset2");
    issue(1'b0, 1, 1, "down1_wrap");

    issue(1'b1, 0, 5, "zero_steps");
    exp_q.push_back(mk(m_idx, m_pos, 1'b0, 1'b0));
    tick_check("idle_after_zero");

    do_reset(1, "reset3");
    issue(1'b1, 3, 0, "up3_p0");
    issue(1'b0, 3, 2, "b2b_down3_p2");

    // Abort mid-run with cmd_valid held throughout.
    do_reset(1, "reset4");
    cmd_valid  = 1'b1;
    cmd_dir    = 1'b1;
    cmd_steps  = 8'd10;
    cmd_period = 8'd2;
    predict(1'b1, 10, 2, 6);
    drain("up10_before_abort");
    cmd_dir    = 1'b0;
    cmd_steps  = 8'd2;
    cmd_period = 8'd1;
    do_reset(2, "abort_reset");
    predict(1'b0, 2, 1, 1 << 20);
    tick_check("accept_after_reset");
    cmd_valid = 1'b0;
    drain("down2_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
